// File: rtl/fec_pkg.sv
// Shared types and bit helpers for the FEC encode sequencer.
// Helpers operate on a FEC_MAX_W container and take the real symbol width as an argument.
package fec_pkg;

  localparam int FEC_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_EMIT    = 2'd3
  } fec_state_e;

  function automatic int popcount(input logic [FEC_MAX_W-1:0] v, input int w);
    int cnt;
    cnt = 0;
    for (int i = 0; i < FEC_MAX_W; i++) begin
      if (i < w && v[i]) cnt++;
    end
    return cnt;
  endfunction

  // Rotation is modulo w, not modulo the container width.
  function automatic logic [FEC_MAX_W-1:0] rotate_left(input logic [FEC_MAX_W-1:0] s,
                                                      input int k, input int w);
    logic [FEC_MAX_W-1:0] res;
    res = '0;
    for (int i = 0; i < FEC_MAX_W; i++) begin
      if (i < w && s[i]) res[(i + k) % w] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fec_coeff_apply.sv
// Combinational coefficient application: XOR of symbol rotations selected by the mask.
// Dense masks are inverted first so at most (W-1)/2 rotations contribute.
module fec_coeff_apply
  import fec_pkg::*;
#(
  parameter int W = 11
) (
  input  logic [W-1:0] mask,
  input  logic [W-1:0] symbol,
  output logic [W-1:0] result
);

  logic [FEC_MAX_W-1:0] w_mask_ext;
  logic [FEC_MAX_W-1:0] w_sym_ext;
  logic [FEC_MAX_W-1:0] w_eff;
  logic [FEC_MAX_W-1:0] w_acc;

  always_comb begin
    w_mask_ext = FEC_MAX_W'(mask);
    w_sym_ext  = FEC_MAX_W'(symbol);
    w_eff      = (popcount(w_mask_ext, W) > (W - 1) / 2) ? ~w_mask_ext : w_mask_ext;
    w_acc      = '0;
    if (mask != '0) begin
      for (int k = 0; k < W; k++) begin
        if (w_eff[k]) w_acc = w_acc ^ rotate_left(w_sym_ext, k, W);
      end
    end
  end

  assign result = w_acc[W-1:0];

endmodule

// File: rtl/fec_encode_sequencer.sv
// Block FEC encoder: loads COLS symbols, then emits ROWS coded symbols, one coefficient per cycle.
// Optional FEC_SKIP_ZERO_EN: COMPUTE visits only nonzero coefficients of each row.
//
// state      | meaning
// IDLE       | waiting for first symbol, coefficient writes accepted
// LOAD       | collecting remaining source symbols
// COMPUTE    | accumulating one coefficient term per cycle for the current row
// EMIT       | presenting the row result until out_ready
module fec_encode_sequencer
  import fec_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int W    = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [$clog2(ROWS)-1:0] cfg_row,
  input  logic [$clog2(COLS)-1:0] cfg_col,
  input  logic [W-1:0]            cfg_coeff,
  output logic                    cfg_ready,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  input  logic [W-1:0]            sym_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_data,
  output logic [$clog2(ROWS)-1:0] out_row,
  output logic                    out_last,
  output logic                    busy
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  fec_state_e    r_state;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_sym   [COLS];
  logic [W-1:0]  r_coeff [ROWS][COLS];

  logic [W-1:0]  w_mask;
  logic [W-1:0]  w_sym;
  logic [W-1:0]  w_term;
  logic [RW-1:0] w_start_row;
  logic [CW-1:0] w_start_col;
  logic [CW-1:0] w_next_col;
  logic          w_has_next;

  assign cfg_ready = (r_state == ST_IDLE);
  assign sym_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_EMIT);
  assign out_data  = out_valid ? r_acc : '0;
  assign out_row   = out_valid ? r_row : '0;
  assign out_last  = out_valid && (r_row == LAST_ROW);

  assign w_mask = r_coeff[r_row][r_col];
  assign w_sym  = r_sym[r_col];

  fec_coeff_apply #(.W(W)) u_apply (
    .mask   (w_mask),
    .symbol (w_sym),
    .result (w_term)
  );

  // Row about to start: row 0 when leaving LOAD, next row when leaving EMIT.
  assign w_start_row = (r_state == ST_EMIT) ? r_row + 1'b1 : '0;

`ifdef FEC_SKIP_ZERO_EN
  // Descending scan so the lowest qualifying column wins; an all-zero row starts at 0.
  always_comb begin
    w_start_col = '0;
    w_next_col  = '0;
    w_has_next  = 1'b0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (r_coeff[w_start_row][c] != '0) w_start_col = CW'(c);
      if (c > int'(r_col) && r_coeff[r_row][c] != '0) begin
        w_has_next = 1'b1;
        w_next_col = CW'(c);
      end
    end
  end
`else
  always_comb begin
    w_start_col = '0;
    w_next_col  = r_col + 1'b1;
    w_has_next  = (r_col != LAST_COL);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_acc   <= '0;
      for (int c = 0; c < COLS; c++) r_sym[c] <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) r_coeff[r][c] <= '0;
      end
    end else begin
      if (cfg_we && cfg_ready) r_coeff[cfg_row][cfg_col] <= cfg_coeff;

      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (sym_valid) begin
            r_sym[r_col] <= sym_data;
            if (r_col == LAST_COL) begin
              r_state <= ST_COMPUTE;
              r_row   <= '0;
              r_col   <= w_start_col;
              r_acc   <= '0;
            end else begin
              r_state <= ST_LOAD;
              r_col   <= r_col + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          r_acc <= r_acc ^ w_term;
          if (w_has_next) begin
            r_col <= w_next_col;
          end else begin
            r_state <= ST_EMIT;
            r_col   <= '0;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            r_acc <= '0;
            if (r_row == LAST_ROW) begin
              r_state <= ST_IDLE;
              r_row   <= '0;
              r_col   <= '0;
            end else begin
              r_state <= ST_COMPUTE;
              r_row   <= r_row + 1'b1;
              r_col   <= w_start_col;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fec_encode_sequencer.sv
// Directed bench for fec_encode_sequencer with hand-computed expected values.
`timescale 1ns/1ps
module tb_fec_encode_sequencer;

  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int W    = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_row = '0;
  logic [1:0]  cfg_col = '0;
  logic [10:0] cfg_coeff = '0;
  logic        cfg_ready;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic [10:0] sym_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] out_data;
  logic [1:0]  out_row;
  logic        out_last;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fec_encode_sequencer #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_row   (cfg_row),
    .cfg_col   (cfg_col),
    .cfg_coeff (cfg_coeff),
    .cfg_ready (cfg_ready),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_data  (sym_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] r, input logic [1:0] c, input logic [10:0] v);
    cfg_we = 1'b1; cfg_row = r; cfg_col = c; cfg_coeff = v;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send_block(input logic [10:0] a, input logic [10:0] b, input logic [10:0] c);
    logic [10:0] s [3];
    int guard;
    s[0] = a; s[1] = b; s[2] = c;
    for (int i = 0; i < 3; i++) begin
      sym_valid = 1'b1;
      sym_data  = s[i];
      guard = 0;
      while (!sym_ready && guard < 50) begin
        tick();
        guard++;
      end
      check($sformatf("sym_ready_sym%0d", i), 32'(sym_ready), 32'd1);
      tick();
    end
    sym_valid = 1'b0;
  endtask

  task automatic expect_row(input string tag, input int row, input logic [10:0] data,
                            input logic last);
    int guard;
    guard = 0;
    while (!out_valid && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(data));
    check({tag, "_row"},   32'(out_row),   32'(row));
    check({tag, "_last"},  32'(out_last),  32'(last));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int ncap;
    logic [10:0] cap_data [4];
    logic [1:0]  cap_row  [4];

    // reset values while rst is held
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_row",   32'(out_row),   32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_sym_ready", 32'(sym_ready), 32'd1);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    tick();

    // identity coefficients
    cfg_write(2'd0, 2'd0, 11'h001);
    cfg_write(2'd1, 2'd1, 11'h001);
    cfg_write(2'd2, 2'd2, 11'h001);
    send_block(11'h123, 11'h456, 11'h789);
    check("ident_busy_after_load", 32'(busy), 32'd1);
    expect_row("ident_r0", 0, 11'h123, 1'b0);
    expect_row("ident_r1", 1, 11'h456, 1'b0);
    expect_row("ident_r2", 2, 11'h789, 1'b1);
    check("ident_idle", 32'(busy), 32'd0);

    // unstalled throughput with coefficients persisting across blocks
    out_ready = 1'b1;
    send_block(11'h123, 11'h456, 11'h789);
    n = 0;
    ncap = 0;
    while (busy && n < 100) begin
      if (out_valid && ncap < 4) begin
        cap_data[ncap] = out_data;
        cap_row[ncap]  = out_row;
        ncap++;
      end
      tick();
      n++;
    end
    out_ready = 1'b0;
`ifdef FEC_SKIP_ZERO_EN
    check("thru_cycles", 32'(n), 32'(2 * ROWS));
`else
    check("thru_cycles", 32'(n), 32'(ROWS * (COLS + 1)));
`endif
    check("thru_count", 32'(ncap), 32'd3);
    check("thru_d0", 32'(cap_data[0]), 32'h123);
    check("thru_d1", 32'(cap_data[1]), 32'h456);
    check("thru_d2", 32'(cap_data[2]), 32'h789);
    check("thru_r2", 32'(cap_row[2]),  32'd2);

    // rotation wrap-around
    cfg_write(2'd1, 2'd1, 11'h000);
    cfg_write(2'd2, 2'd2, 11'h000);
    cfg_write(2'd0, 2'd0, 11'h002);
    send_block(11'h400, 11'h000, 11'h000);
    expect_row("wrap_r0", 0, 11'h001, 1'b0);
    expect_row("wrap_r1", 1, 11'h000, 1'b0);
    expect_row("wrap_r2", 2, 11'h000, 1'b1);

    // inversion threshold: 7FE and 03F inverted, 01F not, 7FF -> zero contribution
    cfg_write(2'd0, 2'd0, 11'h7FE);
    cfg_write(2'd1, 2'd0, 11'h03F);
    cfg_write(2'd1, 2'd1, 11'h003);
    cfg_write(2'd2, 2'd0, 11'h7FF);
    cfg_write(2'd2, 2'd2, 11'h01F);
    send_block(11'h055, 11'h401, 11'h001);

    // stall row 0 for 5 cycles and attempt a cfg write while busy
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("stall_cfg_ready", 32'(cfg_ready), 32'd0);
    check("stall_sym_ready", 32'(sym_ready), 32'd0);
    cfg_we = 1'b1; cfg_row = 2'd0; cfg_col = 2'd0; cfg_coeff = 11'h123;
    for (int i = 0; i < 5; i++) begin
      tick();
      cfg_we = 1'b0;
      check($sformatf("stall_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("stall_data_%0d", i),  32'(out_data),  32'h055);
      check($sformatf("stall_row_%0d", i),   32'(out_row),   32'd0);
    end
    expect_row("inv_r0", 0, 11'h055, 1'b0);
    expect_row("inv_r1", 1, 11'h0F0, 1'b0);
    expect_row("inv_r2", 2, 11'h01F, 1'b1);

    // the write during busy must not have landed
    send_block(11'h055, 11'h401, 11'h001);
    expect_row("persist_r0", 0, 11'h055, 1'b0);
    expect_row("persist_r1", 1, 11'h0F0, 1'b0);
    expect_row("persist_r2", 2, 11'h01F, 1'b1);

    // reset in COMPUTE cycle 2 of row 1
    send_block(11'h055, 11'h401, 11'h001);
    expect_row("mid_r0", 0, 11'h055, 1'b0);
    tick();
    check("mid_busy_before", 32'(busy),      32'd1);
    check("mid_valid_before", 32'(out_valid), 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sym_ready", 32'(sym_ready), 32'd1);
    check("mid_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    tick();
    send_block(11'h7FF, 11'h7FF, 11'h7FF);
    expect_row("clr_r0", 0, 11'h000, 1'b0);
    expect_row("clr_r1", 1, 11'h000, 1'b0);
    expect_row("clr_r2", 2, 11'h000, 1'b1);

    // compute length for a sparse row and an all-zero row
    cfg_write(2'd0, 2'd1, 11'h001);
    send_block(11'h111, 11'h222, 11'h333);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
`ifdef FEC_SKIP_ZERO_EN
    check("sparse_r0_cycles", 32'(n), 32'd1);
`else
    check("sparse_r0_cycles", 32'(n), 32'd3);
`endif
    expect_row("sparse_r0", 0, 11'h222, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
`ifdef FEC_SKIP_ZERO_EN
    check("zero_r1_cycles", 32'(n), 32'd1);
`else
    check("zero_r1_cycles", 32'(n), 32'd3);
`endif
    expect_row("zero_r1", 1, 11'h000, 1'b0);
    expect_row("zero_r2", 2, 11'h000, 1'b1);
    check("end_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
